// File: rtl/sync_fifo_ctl.sv
// ----------------------------------------------------------------------------
// sync_fifo_ctl
//
// Single-clock parametrised FIFO with programmable almost-full/almost-empty
// thresholds, a live occupancy count and sticky overflow/underflow flags.
// The read port can be first-word fall-through (FALLTHROUGH="TRUE") or
// registered (FALLTHROUGH="FALSE").
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   winc       write request, accepted when the FIFO is not full
//   wdata      write data
//   wfull      FIFO holds DEPTH entries
//   awfull     level >= AWFULL_LVL
//   rinc       read request, accepted when the FIFO is not empty
//   rdata      read data (head word in fall-through mode; registered
//              copy of the last read word otherwise)
//   rempty     FIFO holds no entries
//   arempty    level <= AREMPTY_LVL
//   level      current occupancy, 0..DEPTH
//   overflow   sticky: write attempted while full
//   underflow  sticky: read attempted while empty
//   err_clr    clears overflow/underflow (a coincident new error wins)
// ----------------------------------------------------------------------------
module sync_fifo_ctl #(
   parameter int DSIZE       = 8,
   parameter int ASIZE       = 4,
   parameter     FALLTHROUGH = "TRUE",
   parameter int AWFULL_LVL  = (1 << ASIZE) - 1,
   parameter int AREMPTY_LVL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             winc,
   input  logic [DSIZE-1:0] wdata,
   output logic             wfull,
   output logic             awfull,
   input  logic             rinc,
   output logic [DSIZE-1:0] rdata,
   output logic             rempty,
   output logic             arempty,
   output logic [ASIZE:0]   level,
   output logic             overflow,
   output logic             underflow,
   input  logic             err_clr
);

   localparam int DEPTH = 1 << ASIZE;

   localparam logic [ASIZE:0] DEPTH_L   = DEPTH[ASIZE:0];
   localparam logic [ASIZE:0] AWFULL_L  = AWFULL_LVL[ASIZE:0];
   localparam logic [ASIZE:0] AREMPTY_L = AREMPTY_LVL[ASIZE:0];
   localparam logic [ASIZE:0] LVL_ONE   = {{ASIZE{1'b0}}, 1'b1};

   // Reject illegal configurations while elaborating.
   if (AWFULL_LVL < 1 || AWFULL_LVL > DEPTH) begin : g_bad_awfull
      $error("sync_fifo_ctl: AWFULL_LVL=%0d outside 1..%0d", AWFULL_LVL, DEPTH);
   end
   if (AREMPTY_LVL < 0 || AREMPTY_LVL > DEPTH - 1) begin : g_bad_arempty
      $error("sync_fifo_ctl: AREMPTY_LVL=%0d outside 0..%0d", AREMPTY_LVL, DEPTH - 1);
   end
   if (FALLTHROUGH != "TRUE" && FALLTHROUGH != "FALSE") begin : g_bad_mode
      $error("sync_fifo_ctl: FALLTHROUGH must be \"TRUE\" or \"FALSE\"");
   end

   logic [DSIZE-1:0] mem [DEPTH];

   // Pointers carry one extra wrap bit; only the low ASIZE bits address mem.
   logic [ASIZE:0]   wptr;
   logic [ASIZE:0]   rptr;
   logic [ASIZE-1:0] waddr;
   logic [ASIZE-1:0] raddr;
   logic             wa;
   logic             ra;
   logic [ASIZE:0]   level_nxt;

   assign waddr = wptr[ASIZE-1:0];
   assign raddr = rptr[ASIZE-1:0];

   // Acceptance uses the registered flags, so a full FIFO rejects a write
   // even when a read drains an entry in the same cycle.
   assign wa = winc & ~wfull;
   assign ra = rinc & ~rempty;

   // NOTE: level_nxt is assigned a default before any condition so every
   // path drives it and no latch is inferred.
   always_comb begin
      level_nxt = level;
      if (wa && !ra) begin
         level_nxt = level + LVL_ONE;
      end else if (ra && !wa) begin
         level_nxt = level - LVL_ONE;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so all
   // registers sample the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         level     <= '0;
         wfull     <= 1'b0;
         awfull    <= 1'b0;
         rempty    <= 1'b1;
         arempty   <= 1'b1;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wa) wptr <= wptr + LVL_ONE;
         if (ra) rptr <= rptr + LVL_ONE;
         level   <= level_nxt;
         // Flags come from the next level so they line up with level itself.
         wfull   <= (level_nxt == DEPTH_L);
         rempty  <= (level_nxt == '0);
         awfull  <= (level_nxt >= AWFULL_L);
         arempty <= (level_nxt <= AREMPTY_L);
         // A new error in the same cycle as err_clr keeps the flag set.
         overflow  <= (winc & wfull)  | (overflow  & ~err_clr);
         underflow <= (rinc & rempty) | (underflow & ~err_clr);
      end
   end

   // NOTE: storage has no reset; contents are only reachable through the
   // pointers, which reset, so stale words are never observed.
   always_ff @(posedge clk) begin
      if (wa && !rst) begin
         mem[waddr] <= wdata;
      end
   end

   if (FALLTHROUGH == "TRUE") begin : g_fwft
      // Head word is visible with no latency; meaningless while rempty=1.
      assign rdata = mem[raddr];
   end else begin : g_reg
      logic [DSIZE-1:0] rdata_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            rdata_q <= '0;
         end else if (ra) begin
            rdata_q <= mem[raddr];
         end
      end

      assign rdata = rdata_q;
   end

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_ctl
//
// Drives one fall-through and one registered-read instance of sync_fifo_ctl
// (DSIZE=8, ASIZE=2) with identical stimulus and compares both against a
// queue-based reference model after every clock edge.
// ----------------------------------------------------------------------------
module tb_sync_fifo_ctl;

   localparam int DSIZE = 8;
   localparam int ASIZE = 2;
   localparam int DEPTH = 1 << ASIZE;
   localparam int AWFULL = DEPTH - 1;
   localparam int AREMPTY = 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             winc = 1'b0;
   logic [DSIZE-1:0] wdata = '0;
   logic             rinc = 1'b0;
   logic             err_clr = 1'b0;

   logic             wfull_t, awfull_t, rempty_t, arempty_t, ovf_t, unf_t;
   logic [DSIZE-1:0] rdata_t;
   logic [ASIZE:0]   level_t;
   logic             wfull_r, awfull_r, rempty_r, arempty_r, ovf_r, unf_r;
   logic [DSIZE-1:0] rdata_r;
   logic [ASIZE:0]   level_r;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [DSIZE-1:0] q[$];
   logic [DSIZE-1:0] m_rd_hold = '0;
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_ctl #(
      .DSIZE(DSIZE), .ASIZE(ASIZE), .FALLTHROUGH("TRUE"),
      .AWFULL_LVL(AWFULL), .AREMPTY_LVL(AREMPTY)
   ) u_dut_ft (
      .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull_t),
      .awfull(awfull_t), .rinc(rinc), .rdata(rdata_t), .rempty(rempty_t),
      .arempty(arempty_t), .level(level_t), .overflow(ovf_t),
      .underflow(unf_t), .err_clr(err_clr)
   );

   sync_fifo_ctl #(
      .DSIZE(DSIZE), .ASIZE(ASIZE), .FALLTHROUGH("FALSE"),
      .AWFULL_LVL(AWFULL), .AREMPTY_LVL(AREMPTY)
   ) u_dut_reg (
      .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull_r),
      .awfull(awfull_r), .rinc(rinc), .rdata(rdata_r), .rempty(rempty_r),
      .arempty(arempty_r), .level(level_r), .overflow(ovf_r),
      .underflow(unf_r), .err_clr(err_clr)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Model: behaviour derived from occupancy rules on a plain queue.
   task automatic model_step(input logic w, input logic [DSIZE-1:0] wd,
                             input logic r, input logic clr, input logic rs);
      int  n;
      bit  acc_w, acc_r, set_o, set_u;
      if (rs) begin
         q.delete();
         m_rd_hold = '0;
         m_ovf = 1'b0;
         m_unf = 1'b0;
         return;
      end
      n     = q.size();
      acc_w = w && (n < DEPTH);
      acc_r = r && (n > 0);
      set_o = w && (n == DEPTH);
      set_u = r && (n == 0);
      if (acc_r) m_rd_hold = q.pop_front();
      if (acc_w) q.push_back(wd);
      m_ovf = set_o || (m_ovf && !clr);
      m_unf = set_u || (m_unf && !clr);
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      check("level_t",   32'(level_t),   32'(n));
      check("level_r",   32'(level_r),   32'(n));
      check("rempty_t",  32'(rempty_t),  32'(n == 0));
      check("rempty_r",  32'(rempty_r),  32'(n == 0));
      check("wfull_t",   32'(wfull_t),   32'(n == DEPTH));
      check("wfull_r",   32'(wfull_r),   32'(n == DEPTH));
      check("awfull_t",  32'(awfull_t),  32'(n >= AWFULL));
      check("awfull_r",  32'(awfull_r),  32'(n >= AWFULL));
      check("arempty_t", 32'(arempty_t), 32'(n <= AREMPTY));
      check("arempty_r", 32'(arempty_r), 32'(n <= AREMPTY));
      check("ovf_t",     32'(ovf_t),     32'(m_ovf));
      check("ovf_r",     32'(ovf_r),     32'(m_ovf));
      check("unf_t",     32'(unf_t),     32'(m_unf));
      check("unf_r",     32'(unf_r),     32'(m_unf));
      check("rdata_r",   32'(rdata_r),   32'(m_rd_hold));
      if (n > 0) check("rdata_t", 32'(rdata_t), 32'(q[0]));
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, check.
   task automatic cycle(input logic w, input logic [DSIZE-1:0] wd,
                        input logic r, input logic clr, input logic rs);
      winc    = w;
      wdata   = wd;
      rinc    = r;
      err_clr = clr;
      rst     = rs;
      @(posedge clk);
      model_step(w, wd, r, clr, rs);
      #1;
      check_all();
   endtask

   initial begin
      // Reset, with stray requests that must be dropped.
      cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("rst_rempty",  32'(rempty_t),  32'd1);
      check("rst_arempty", 32'(arempty_t), 32'd1);
      check("rst_rdata_r", 32'(rdata_r),   32'd0);

      // Single write from reset: fall-through word visible next cycle.
      cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
      check("a1_rdata_t",  32'(rdata_t),   32'hA1);
      check("a1_level",    32'(level_t),   32'd1);
      check("a1_arempty",  32'(arempty_t), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Fill to full, then one write too many.
      for (int i = 1; i <= 4; i++) begin
         cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         check("fill_level", 32'(level_t), 32'(i));
      end
      check("fill_wfull", 32'(wfull_t), 32'd1);
      cycle(1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
      check("ovf_level", 32'(level_t), 32'd4);
      check("ovf_flag",  32'(ovf_t),   32'd1);

      // Write and read together while full: read wins, write rejected.
      cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
      check("full_wr_level",  32'(level_t), 32'd3);
      check("full_wr_rdata_r", 32'(rdata_r), 32'h01);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // Streaming through pointer wrap at constant level.
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
      check("stream_level", 32'(level_t), 32'd3);
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Registered-read behaviour and underflow.
      cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("reg_rd1", 32'(rdata_r), 32'h55);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("reg_rd2", 32'(rdata_r), 32'h66);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("reg_unf",  32'(unf_r),   32'd1);
      check("reg_hold", 32'(rdata_r), 32'h66);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // Reach level 3 with overflow set, then reset mid-traffic.
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("pre_rst_level", 32'(level_t), 32'd3);
      check("pre_rst_ovf",   32'(ovf_t),   32'd1);
      cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
      check("rst2_level",   32'(level_r), 32'd0);
      check("rst2_ovf",     32'(ovf_r),   32'd0);
      check("rst2_rdata_r", 32'(rdata_r), 32'd0);
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      check("set_wins", 32'(unf_t), 32'd1);

      // Randomised traffic with phases biased toward full and toward empty.
      for (int i = 0; i < 600; i++) begin
         int  wp;
         logic w, r, c, rs;
         wp = ((i / 40) % 2 == 0) ? 75 : 25;
         w  = ($urandom_range(0, 99) < wp);
         r  = ($urandom_range(0, 99) < (100 - wp));
         c  = ($urandom_range(0, 99) < 5);
         rs = ($urandom_range(0, 99) < 1);
         cycle(w, 8'($urandom), r, c, rs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
